// File: rtl/fpm_pkg.sv
// Shared types and constants for the radix-8 Booth floating-point multiplier datapath.
package fpm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        DONE
    } pp_csa_state_e;

    localparam int RADIX8_SHIFT = 3;

    function automatic int ceilDiv(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/pp_csa_reducer_if.sv
// Valid/ready bundle between the Booth encoder, the CSA reducer and the final adder.
// The in_addend signal exists only when PP_CSA_REDUCER_ADDEND_EN is defined.
interface pp_csa_reducer_if #(
    parameter int NUM_PP = 9,
    parameter int PP_W   = 27,
    parameter int OUT_W  = 48
);
    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_PP*PP_W-1:0] in_pp;
`ifdef PP_CSA_REDUCER_ADDEND_EN
    logic [OUT_W-1:0]       in_addend;
`endif
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       out_sum;
    logic [OUT_W-1:0]       out_carry;

    modport master (
        output in_valid, in_pp, out_ready,
`ifdef PP_CSA_REDUCER_ADDEND_EN
        output in_addend,
`endif
        input  in_ready, out_valid, out_sum, out_carry
    );

    modport slave (
        input  in_valid, in_pp, out_ready,
`ifdef PP_CSA_REDUCER_ADDEND_EN
        input  in_addend,
`endif
        output in_ready, out_valid, out_sum, out_carry
    );

endinterface

// File: rtl/pp_csa_reducer_csa_row.sv
// One row of 3:2 carry-save full adders; the carry row comes out already shifted to its weight.
module csa_row #(
    parameter int W = 48
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    assign sum_o = a_i ^ b_i ^ c_i;

    // The top-bit majority would land at weight 2^W and is dropped by the modular arithmetic.
    assign carry_o = {(a_i[W-2:0] & b_i[W-2:0]) |
                      (a_i[W-2:0] & c_i[W-2:0]) |
                      (b_i[W-2:0] & c_i[W-2:0]), 1'b0};

endmodule

// File: rtl/pp_csa_reducer.sv
// Multi-cycle carry-save reducer: folds PP_PER_CYCLE Booth rows per clock into a sum/carry pair.
// Defining PP_CSA_REDUCER_ADDEND_EN preloads in_addend into the accumulator (fused MAC).
module pp_csa_reducer
    import fpm_pkg::*;
#(
    parameter int NUM_PP       = 9,
    parameter int PP_W         = 27,
    parameter int OUT_W        = 48,
    parameter int PP_PER_CYCLE = 3
) (
    input logic              clk,
    input logic              rst,
    pp_csa_reducer_if.slave  bus
);

    localparam int G    = ceilDiv(NUM_PP, PP_PER_CYCLE);
    localparam int GW   = (G > 1) ? $clog2(G) : 1;
    localparam int NPAD = G * PP_PER_CYCLE;

    pp_csa_state_e          state_q, state_d;
    logic [GW-1:0]          grp_q, grp_d;
    logic [NUM_PP*PP_W-1:0] pp_q, pp_d;
    logic [OUT_W-1:0]       accSum_q, accSum_d;
    logic [OUT_W-1:0]       accCarry_q, accCarry_d;

    logic                   inReady;
    logic [OUT_W-1:0]       rowShifted [NPAD];
    logic [OUT_W-1:0]       grpRow [PP_PER_CYCLE];

    function automatic logic [OUT_W-1:0] shiftRow(input logic [PP_W-1:0] row, input int idx);
        logic [OUT_W-1:0] ext;
        ext = OUT_W'(row);
        return ext << (RADIX8_SHIFT * idx);
    endfunction

    // Rows past NUM_PP pad the last group with zeros so every group has the same shape.
    for (genvar i = 0; i < NPAD; i++) begin : g_row
        if (i < NUM_PP) begin : g_live
            assign rowShifted[i] = shiftRow(pp_q[i*PP_W +: PP_W], i);
        end else begin : g_pad
            assign rowShifted[i] = '0;
        end
    end

    always_comb begin
        for (int k = 0; k < PP_PER_CYCLE; k++) begin
            grpRow[k] = '0;
            for (int g = 0; g < G; g++) begin
                if (grp_q == GW'(g)) begin
                    grpRow[k] = rowShifted[g*PP_PER_CYCLE + k];
                end
            end
        end
    end

    for (genvar k = 0; k < PP_PER_CYCLE; k++) begin : g_csa
        logic [OUT_W-1:0] s;
        logic [OUT_W-1:0] c;
        if (k == 0) begin : g_first
            csa_row #(.W(OUT_W)) u_csa (
                .a_i(accSum_q), .b_i(accCarry_q), .c_i(grpRow[k]),
                .sum_o(s), .carry_o(c)
            );
        end else begin : g_next
            csa_row #(.W(OUT_W)) u_csa (
                .a_i(g_csa[k-1].s), .b_i(g_csa[k-1].c), .c_i(grpRow[k]),
                .sum_o(s), .carry_o(c)
            );
        end
    end

    always_comb begin
        state_d    = state_q;
        grp_d      = grp_q;
        pp_d       = pp_q;
        accSum_d   = accSum_q;
        accCarry_d = accCarry_q;
        inReady    = 1'b0;

        case (state_q)
            IDLE: inReady = 1'b1;
            REDUCE: begin
                accSum_d   = g_csa[PP_PER_CYCLE-1].s;
                accCarry_d = g_csa[PP_PER_CYCLE-1].c;
                grp_d      = grp_q + 1'b1;
                if (grp_q == GW'(G - 1)) begin
                    state_d = DONE;
                    grp_d   = '0;
                end
            end
            DONE: begin
                inReady = bus.out_ready;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Acceptance overrides the DONE->IDLE step so sets can run back-to-back.
        if (inReady && bus.in_valid) begin
            pp_d       = bus.in_pp;
`ifdef PP_CSA_REDUCER_ADDEND_EN
            accSum_d   = bus.in_addend;
`else
            accSum_d   = '0;
`endif
            accCarry_d = '0;
            grp_d      = '0;
            state_d    = REDUCE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grp_q      <= '0;
            pp_q       <= '0;
            accSum_q   <= '0;
            accCarry_q <= '0;
        end else begin
            state_q    <= state_d;
            grp_q      <= grp_d;
            pp_q       <= pp_d;
            accSum_q   <= accSum_d;
            accCarry_q <= accCarry_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = accSum_q;
    assign bus.out_carry = accCarry_q;

endmodule
